// File: rtl/axi_master_pkg.sv
// Shared types and constants for the AXI burst write master.
// Holds the write-command layout, the splitter FSM states and small helpers.
package axi_master_pkg;

    localparam int AXI_ADDR_W          = 64;
    localparam int AXI_DATA_W          = 128;
    localparam int AXI_LEN_W           = 8;
    localparam int AXI_ID_W            = 4;
    localparam int AXI_SIZE_W          = 3;
    localparam int AXI_PAGE_SIZE_BYTES = 4096;
    localparam int AXI_BEATS_W         = 32;

    localparam int MAX_BURST_BEATS      = 256;
    localparam int DATA_W_BYTES_CLOG    = $clog2(AXI_DATA_W / 8);
    localparam int PAGE_SIZE_BYTES_CLOG = $clog2(AXI_PAGE_SIZE_BYTES);

    // Write command as presented to the master's command FIFO, MSB first.
    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic [AXI_LEN_W-1:0]  len;
        logic [AXI_SIZE_W-1:0] size;
        logic [AXI_ID_W-1:0]   id;
    } wr_cmd_t;

    localparam int WR_CMD_W = $bits(wr_cmd_t);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_ISSUE = 2'd2
    } split_state_e;

    function automatic logic [AXI_BEATS_W-1:0] min_beats(
        input logic [AXI_BEATS_W-1:0] a,
        input logic [AXI_BEATS_W-1:0] b
    );
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_wr_cmd_splitter.sv
// Splits one user write request into legal AXI write bursts.
// Optional feature macro: AXI_CMD_SPLIT_PAGE_EN - when defined, no burst
// crosses a PAGE_SIZE_BYTES boundary; otherwise bursts are only capped at
// MAX_BURST_BEATS.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for a request; latches aligned addr, beat count, id
// ST_CALC  | sizes the next burst from remaining beats (and page room)
// ST_ISSUE | presents the burst command until the downstream accepts it
module axi_wr_cmd_splitter
    import axi_master_pkg::*;
#(
    parameter int ADDR_W          = AXI_ADDR_W,
    parameter int DATA_W          = AXI_DATA_W,
    parameter int LEN_W           = AXI_LEN_W,
    parameter int ID_W            = AXI_ID_W,
    parameter int PAGE_SIZE_BYTES = AXI_PAGE_SIZE_BYTES,
    parameter int BEATS_W         = AXI_BEATS_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [BEATS_W-1:0]  req_beats,
    input  logic [ID_W-1:0]     req_id,
    output logic                cmd_valid,
    input  logic                cmd_ready,
    output logic [WR_CMD_W-1:0] cmd_data,
    output logic                cmd_last,
    output logic                busy
);

    // The burst arithmetic relies on the package's log2 constants matching
    // the parameters actually used for this instance.
    if ((DATA_W / 8) != (1 << DATA_W_BYTES_CLOG) ||
        PAGE_SIZE_BYTES != (1 << PAGE_SIZE_BYTES_CLOG) ||
        PAGE_SIZE_BYTES < (DATA_W / 8)) begin : g_cfg_err
        $error("axi_wr_cmd_splitter: inconsistent DATA_W / PAGE_SIZE_BYTES");
    end

    split_state_e r_state;
    split_state_e w_next;

    logic [ADDR_W-1:0]  r_addr;
    logic [BEATS_W-1:0] r_rem;
    logic [BEATS_W-1:0] r_beats;
    logic [ID_W-1:0]    r_id;
    logic               r_last;

    logic [BEATS_W-1:0] w_beats;
    wr_cmd_t            w_cmd;

`ifdef AXI_CMD_SPLIT_PAGE_EN
    // Page room in beats is one bit wider than the in-page beat offset so a
    // page-aligned address yields a full page rather than zero.
    localparam int PB_W = PAGE_SIZE_BYTES_CLOG - DATA_W_BYTES_CLOG + 1;
    localparam logic [PB_W-1:0] PAGE_BEATS = PB_W'(1) << (PB_W - 1);

    logic [PB_W-1:0] w_page_beats;

    // Beats left before the next page boundary; address is beat aligned.
    always_comb begin
        w_page_beats = PAGE_BEATS
                     - {1'b0, r_addr[PAGE_SIZE_BYTES_CLOG-1:DATA_W_BYTES_CLOG]};
        w_beats      = min_beats(min_beats(r_rem, BEATS_W'(MAX_BURST_BEATS)),
                                 BEATS_W'(w_page_beats));
    end
`else
    // Burst size limited only by the remaining count and the AXI maximum.
    always_comb begin
        w_beats = min_beats(r_rem, BEATS_W'(MAX_BURST_BEATS));
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and state-decoded outputs; outputs never see req_valid or cmd_ready.
    always_comb begin
        w_next       = r_state;
        req_ready    = 1'b0;
        cmd_valid    = 1'b0;
        cmd_last     = 1'b0;
        busy         = 1'b1;
        cmd_data     = '0;
        w_cmd.addr   = r_addr;
        w_cmd.len    = LEN_W'(r_beats - BEATS_W'(1));
        w_cmd.size   = AXI_SIZE_W'(DATA_W_BYTES_CLOG);
        w_cmd.id     = r_id;
        case (r_state)
            ST_IDLE: begin
                req_ready = ~rst;
                busy      = 1'b0;
                if (req_valid && (req_beats != '0)) begin
                    w_next = ST_CALC;
                end
            end
            ST_CALC: begin
                w_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                cmd_valid = 1'b1;
                cmd_last  = r_last;
                cmd_data  = w_cmd;
                if (cmd_ready) begin
                    w_next = r_last ? ST_IDLE : ST_CALC;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Request latch, burst sizing and per-burst address/remaining update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_rem   <= '0;
            r_beats <= '0;
            r_id    <= '0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_addr <= {req_addr[ADDR_W-1:DATA_W_BYTES_CLOG],
                                   {DATA_W_BYTES_CLOG{1'b0}}};
                        r_rem  <= req_beats;
                        r_id   <= req_id;
                    end
                end
                ST_CALC: begin
                    r_beats <= w_beats;
                    r_last  <= (r_rem == w_beats);
                end
                ST_ISSUE: begin
                    if (cmd_ready) begin
                        r_addr <= r_addr + (ADDR_W'(r_beats) << DATA_W_BYTES_CLOG);
                        r_rem  <= r_rem - r_beats;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_cmd_splitter.sv
// Self-checking bench for axi_wr_cmd_splitter: directed scenarios plus
// randomized requests against a burst-list reference model.
module tb_axi_wr_cmd_splitter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [63:0]  req_addr = '0;
    logic [31:0]  req_beats = '0;
    logic [3:0]   req_id = '0;
    logic         cmd_valid;
    logic         cmd_ready = 1'b1;
    logic [78:0]  cmd_data;
    logic         cmd_last;
    logic         busy;

    always #5 clk = ~clk;

    axi_wr_cmd_splitter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_beats (req_beats),
        .req_id    (req_id),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_last  (cmd_last),
        .busy      (busy)
    );

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [3:0]  id;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          hs_count = 0;
    int          neg_cyc = 0;
    int          hs_cyc[$];
    int          rdy_mode = 0;
    logic        stall_prev = 1'b0;
    logic [78:0] stall_data = '0;
    logic        stall_last = 1'b0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: walk the request in bursts, each the largest allowed size.
    function automatic void model(input logic [63:0] a_in, input int unsigned beats,
                                  input logic [3:0] id);
        logic [63:0] a;
        int unsigned rem;
        int unsigned n;
        int unsigned room;
        exp_t        e;
        a   = a_in & ~64'hF;
        rem = beats;
        while (rem > 0) begin
            n = (rem > 256) ? 256 : rem;
`ifdef AXI_CMD_SPLIT_PAGE_EN
            room = (4096 - int'(a % 4096)) / 16;
            if (n > room) n = room;
`else
            room = 0;
`endif
            e.addr = a;
            e.len  = 8'(n - 1);
            e.id   = id;
            e.last = (rem == n);
            exp_q.push_back(e);
            a   = a + 64'(n) * 64'd16;
            rem = rem - n;
        end
    endfunction

    // Observe handshakes and hold-while-stalled between clock edges.
    always @(negedge clk) begin
        neg_cyc++;
        if (!rst && cmd_valid && stall_prev) begin
            chk("stall_hold_data", cmd_data, stall_data);
            chk("stall_hold_last", cmd_last, stall_last);
        end
        if (!rst && cmd_valid && cmd_ready) begin
            hs_count++;
            hs_cyc.push_back(neg_cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_cmd", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("cmd_addr", cmd_data[78:15], mon_e.addr);
                chk("cmd_len",  cmd_data[14:7],  mon_e.len);
                chk("cmd_size", cmd_data[6:4],   3'd4);
                chk("cmd_id",   cmd_data[3:0],   mon_e.id);
                chk("cmd_last", cmd_last,        mon_e.last);
            end
        end
        stall_prev = !rst && cmd_valid && !cmd_ready;
        stall_data = cmd_data;
        stall_last = cmd_last;
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: cmd_ready = 1'b1;
            1: cmd_ready = 1'($urandom_range(0, 1));
            default: ;
        endcase
    end

    task automatic send_req(input logic [63:0] a, input int unsigned n, input logic [3:0] id);
        int w = 0;
        @(negedge clk);
        while (!req_ready && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) chk("req_ready_timeout", 0, 1);
        req_valid = 1'b1;
        req_addr  = a;
        req_beats = n;
        req_id    = id;
        model(a, n, id);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!((exp_q.size() == 0) && !busy) && w < 6000);
        chk("drain_left", exp_q.size(), 0);
        chk("drain_busy", busy, 0);
    endtask

    initial begin
        int h0;
        int w;
        logic [78:0] snap;
        logic [63:0] ra;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_data",  cmd_data,  0);
        chk("rst_cmd_last",  cmd_last,  0);
        chk("rst_busy",      busy,      0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", req_ready, 1);

        // single burst, plus request-to-command latency
        h0 = hs_count;
        send_req(64'h1000, 16, 4'd3);
        @(negedge clk);
        chk("calc_cmd_valid", cmd_valid, 0);
        chk("calc_busy",      busy,      1);
        chk("calc_req_ready", req_ready, 0);
        @(negedge clk);
        chk("first_cmd_lat",  cmd_valid, 1);
        wait_idle();
        chk("single_count", hs_count - h0, 1);

        // 600 beats: three bursts, one every two cycles
        h0 = hs_cyc.size();
        send_req(64'h0, 600, 4'd9);
        wait_idle();
        chk("split600_count", hs_cyc.size() - h0, 3);
        if (hs_cyc.size() >= h0 + 3) begin
            chk("thru_gap1", hs_cyc[h0+1] - hs_cyc[h0], 2);
            chk("thru_gap2", hs_cyc[h0+2] - hs_cyc[h0+1], 2);
        end

        // page straddle
        h0 = hs_count;
        send_req(64'h0F80, 16, 4'd1);
        wait_idle();
`ifdef AXI_CMD_SPLIT_PAGE_EN
        chk("page_count", hs_count - h0, 2);
`else
        chk("page_count", hs_count - h0, 1);
`endif

        // backpressure: 5 stalled cycles, handshake on the 6th
        rdy_mode  = 2;
        cmd_ready = 1'b0;
        h0 = hs_count;
        send_req(64'h3000, 4, 4'd5);
        w = 0;
        while (!cmd_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("bp_valid_seen", cmd_valid, 1);
        snap = cmd_data;
        chk("bp_addr", snap[78:15], 64'h3000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_valid_hold", cmd_valid, 1);
            chk("bp_data_hold",  cmd_data,  snap);
        end
        chk("bp_no_hs", hs_count - h0, 0);
        @(posedge clk);
        #1;
        cmd_ready = 1'b1;
        rdy_mode  = 0;
        wait_idle();
        chk("bp_count", hs_count - h0, 1);

        // zero-beat request
        h0 = hs_count;
        send_req(64'h7000, 0, 4'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("zero_req_ready", req_ready, 1);
            chk("zero_busy",      busy,      0);
            chk("zero_cmd_valid", cmd_valid, 0);
        end
        chk("zero_count", hs_count - h0, 0);

        // reset after the first command of a long request
        h0 = hs_count;
        send_req(64'h0, 600, 4'd6);
        w = 0;
        while (hs_count == h0 && w < 50) begin
            @(posedge clk);
            w++;
        end
        chk("rst_mid_first_hs", hs_count - h0, 1);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_req_ready", req_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rst_mid_cmd_valid", cmd_valid, 0);
        chk("rst_mid_busy",      busy,      0);
        h0 = hs_count;
        send_req(64'h5000, 1, 4'd7);
        wait_idle();
        chk("post_rst_count", hs_count - h0, 1);

        // randomized requests under random backpressure
        rdy_mode = 1;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0: ra = {$urandom, $urandom};
                1: ra = ({$urandom, $urandom} & ~64'hFFF) | 64'hF00 | 64'($urandom_range(0, 255));
                2: ra = 64'hFFFF_FFFF_FFFF_F000 + 64'($urandom_range(0, 4095));
                default: ra = 64'($urandom_range(0, 16'hFFFF));
            endcase
            case ($urandom_range(0, 5))
                0: send_req(ra, 0, 4'($urandom));
                1: send_req(ra, $urandom_range(257, 700), 4'($urandom));
                default: send_req(ra, $urandom_range(1, 40), 4'($urandom));
            endcase
        end
        wait_idle();
        rdy_mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
